// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 SPI receive-side monitor:
// command codes, decoder state encoding, window defaults and the
// bundle of synchronised SPI pins.
package ili9341_pkg;

   // ILI9341 commands the monitor understands
   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   // Default panel geometry and window origin
   localparam int         DEF_WIDTH  = 240;
   localparam int         DEF_HEIGHT = 320;
   localparam logic [8:0] DEF_XS     = 9'd0;
   localparam logic [8:0] DEF_YS     = 9'd0;

   // Command decoder states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CASET,
      ST_PASET,
      ST_RAMWR_HI,
      ST_RAMWR_LO,
      ST_SKIP
   } dec_state_t;

   // One sample of the SPI pins as they travel down the synchroniser
   typedef struct packed {
      logic rst_n;
      logic cs_n;
      logic sclk;
      logic din;
      logic dc;
   } spi_pins_t;

   // Pin values of an idle, out-of-reset link
   localparam spi_pins_t PINS_IDLE = '{rst_n: 1'b1, cs_n: 1'b1, sclk: 1'b0,
                                       din: 1'b0, dc: 1'b0};

   // A window is legal when it is non-empty and ends inside the panel
   function automatic logic window_ok(input logic [15:0] start_v,
                                      input logic [15:0] end_v,
                                      input logic [15:0] limit);
      return (start_v <= end_v) && (end_v < limit);
   endfunction

endpackage

// File: rtl/ili9341_spi_rx.sv
// SPI byte receiver: synchronises the panel pins to sysclk, detects
// rising edges of tft_clk and deserialises MSB-first bytes. Each byte
// is tagged as command or data using tft_dc sampled with its last bit.
// SYNC_STAGES must be at least 2.
module ili9341_spi_rx
   import ili9341_pkg::*;
#(
   parameter int SYNC_STAGES = 2
)
(
   input  logic       sysclk,
   input  logic       rst,
   input  logic       tft_rst,
   input  logic       tft_cs,
   input  logic       tft_clk,
   input  logic       tft_din,
   input  logic       tft_dc,
   output logic       tft_rst_s,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_is_cmd
);

   spi_pins_t  sync_q [SYNC_STAGES];
   spi_pins_t  pins;
   logic       sclk_d;
   logic       sclk_rise;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic       done;
   logic       dc_q;

   assign pins      = sync_q[SYNC_STAGES-1];
   assign tft_rst_s = pins.rst_n;
   assign sclk_rise = pins.sclk & ~sclk_d;

   // Synchroniser chain for all panel inputs
   // NOTE: sequential state always uses <=, so every flop samples the
   // pre-edge value of its neighbour and the chain shifts by one per edge.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PINS_IDLE;
      end else begin
         sync_q[0] <= '{rst_n: tft_rst, cs_n: tft_cs, sclk: tft_clk,
                        din: tft_din, dc: tft_dc};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Delayed copy of the synchronised clock for edge detection
   always_ff @(posedge sysclk) begin
      if (rst) sclk_d <= 1'b0;
      else     sclk_d <= pins.sclk;
   end

   // Bit capture; a deselect drops any partial byte
   always_ff @(posedge sysclk) begin
      if (rst || !pins.rst_n) begin
         bit_cnt <= 3'd0;
         shreg   <= 8'd0;
         done    <= 1'b0;
         dc_q    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (pins.cs_n) begin
            bit_cnt <= 3'd0;
         end else if (sclk_rise) begin
            shreg   <= {shreg[6:0], pins.din};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               done <= 1'b1;
               dc_q <= pins.dc;
            end
         end
      end
   end

   // Present the completed byte one cycle after its last bit
   always_ff @(posedge sysclk) begin
      if (rst) begin
         byte_valid  <= 1'b0;
         byte_data   <= 8'd0;
         byte_is_cmd <= 1'b0;
      end else begin
         byte_valid <= done;
         if (done) begin
            byte_data   <= shreg;
            byte_is_cmd <= ~dc_q;
         end
      end
   end

endmodule

// File: rtl/ili9341_spi_monitor.sv
// Receive-side model of the ILI9341 4-wire SPI link. Bytes come from
// ili9341_spi_rx; this level decodes CASET/PASET/RAMWR, keeps the
// address window and cursor, and emits one addressed RGB565 pixel per
// completed RAMWR pixel.
// Build option: define ILI_MON_STATS_EN to add saturating cmd_count and
// pix_count outputs.
module ili9341_spi_monitor
   import ili9341_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int WIDTH       = DEF_WIDTH,
   parameter int HEIGHT      = DEF_HEIGHT
)
(
   input  logic        sysclk,
   input  logic        rst,
   input  logic        tft_rst,
   input  logic        tft_cs,
   input  logic        tft_clk,
   input  logic        tft_din,
   input  logic        tft_dc,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        byte_is_cmd,
   output logic        pix_valid,
   output logic [8:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic [15:0] pix_data,
   output logic        cmd_err
`ifdef ILI_MON_STATS_EN
   ,
   output logic [15:0] cmd_count,
   output logic [31:0] pix_count
`endif
);

   localparam logic [8:0]  XE_RST = 9'(WIDTH - 1);
   localparam logic [8:0]  YE_RST = 9'(HEIGHT - 1);
   localparam logic [15:0] W_LIM  = 16'(WIDTH);
   localparam logic [15:0] H_LIM  = 16'(HEIGHT);

   logic        tft_rst_s;
   dec_state_t  state;
   logic [1:0]  arg_idx;
   logic [15:0] arg_start;
   logic [7:0]  arg_end_hi;
   logic [15:0] arg_end;
   logic [15:0] win_lim;
   logic        win_ok;
   logic [8:0]  xs, xe, ys, ye;
   logic [8:0]  cur_x, cur_y;
   logic [8:0]  nxt_x, nxt_y;
   logic [7:0]  pix_hi;

   ili9341_spi_rx #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rx (
      .sysclk      (sysclk),
      .rst         (rst),
      .tft_rst     (tft_rst),
      .tft_cs      (tft_cs),
      .tft_clk     (tft_clk),
      .tft_din     (tft_din),
      .tft_dc      (tft_dc),
      .tft_rst_s   (tft_rst_s),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_is_cmd (byte_is_cmd)
   );

   // Window argument check against the axis being programmed
   // NOTE: every always_comb output gets a default before any branch so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      arg_end = {arg_end_hi, byte_data};
      win_lim = W_LIM;
      if (state == ST_PASET) win_lim = H_LIM;
      win_ok = window_ok(arg_start, arg_end, win_lim);
   end

   // Cursor step: raster order inside the window, wrapping at frame end
   always_comb begin
      nxt_x = cur_x + 9'd1;
      nxt_y = cur_y;
      if (cur_x == xe) begin
         nxt_x = xs;
         if (cur_y == ye) nxt_y = ys;
         else             nxt_y = cur_y + 9'd1;
      end
   end

   // Command decoder, window registers and pixel assembly
   always_ff @(posedge sysclk) begin
      if (rst || !tft_rst_s) begin
         state      <= ST_IDLE;
         arg_idx    <= 2'd0;
         arg_start  <= 16'd0;
         arg_end_hi <= 8'd0;
         xs         <= DEF_XS;
         xe         <= XE_RST;
         ys         <= DEF_YS;
         ye         <= YE_RST;
         cur_x      <= DEF_XS;
         cur_y      <= DEF_YS;
         pix_hi     <= 8'd0;
         pix_valid  <= 1'b0;
         pix_x      <= 9'd0;
         pix_y      <= 9'd0;
         pix_data   <= 16'd0;
         cmd_err    <= 1'b0;
      end else begin
         pix_valid <= 1'b0;
         if (byte_valid) begin
            if (byte_is_cmd) begin
               // Any command abandons a half-received pixel by leaving RAMWR_LO
               arg_idx <= 2'd0;
               case (byte_data)
                  CMD_CASET: state <= ST_CASET;
                  CMD_PASET: state <= ST_PASET;
                  CMD_RAMWR: begin
                     state <= ST_RAMWR_HI;
                     cur_x <= xs;
                     cur_y <= ys;
                  end
                  default:   state <= ST_SKIP;
               endcase
            end else begin
               case (state)
                  ST_CASET, ST_PASET: begin
                     case (arg_idx)
                        2'd0:    arg_start[15:8] <= byte_data;
                        2'd1:    arg_start[7:0]  <= byte_data;
                        2'd2:    arg_end_hi      <= byte_data;
                        default: begin
                           if (!win_ok) begin
                              cmd_err <= 1'b1;
                           end else if (state == ST_CASET) begin
                              xs <= arg_start[8:0];
                              xe <= arg_end[8:0];
                           end else begin
                              ys <= arg_start[8:0];
                              ye <= arg_end[8:0];
                           end
                           state <= ST_SKIP;
                        end
                     endcase
                     arg_idx <= arg_idx + 2'd1;
                  end
                  ST_RAMWR_HI: begin
                     pix_hi <= byte_data;
                     state  <= ST_RAMWR_LO;
                  end
                  ST_RAMWR_LO: begin
                     pix_valid <= 1'b1;
                     pix_x     <= cur_x;
                     pix_y     <= cur_y;
                     pix_data  <= {pix_hi, byte_data};
                     cur_x     <= nxt_x;
                     cur_y     <= nxt_y;
                     state     <= ST_RAMWR_HI;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

`ifdef ILI_MON_STATS_EN
   // Saturating traffic counters
   always_ff @(posedge sysclk) begin
      if (rst || !tft_rst_s) begin
         cmd_count <= 16'd0;
         pix_count <= 32'd0;
      end else begin
         if (byte_valid && byte_is_cmd && (cmd_count != 16'hFFFF))
            cmd_count <= cmd_count + 16'd1;
         if (pix_valid && (pix_count != 32'hFFFF_FFFF))
            pix_count <= pix_count + 32'd1;
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ili9341_spi_monitor.sv
// Directed bench for ili9341_spi_monitor: drives SPI mode-0 traffic,
// logs byte and pixel pulses, and compares them with hand-computed values.
module tb_ili9341_spi_monitor;

   logic        sysclk = 1'b0;
   logic        rst;
   logic        tft_rst;
   logic        tft_cs;
   logic        tft_clk;
   logic        tft_din;
   logic        tft_dc;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_is_cmd;
   logic        pix_valid;
   logic [8:0]  pix_x;
   logic [8:0]  pix_y;
   logic [15:0] pix_data;
   logic        cmd_err;
`ifdef ILI_MON_STATS_EN
   logic [15:0] cmd_count;
   logic [31:0] pix_count;
`endif

   int total = 0;
   int bad   = 0;
   int overlap = 0;

   logic [8:0]  byte_q[$];
   logic [33:0] pix_q[$];
   time         bv_t_q[$];
   time         rise_q[$];

   ili9341_spi_monitor dut (
      .sysclk      (sysclk),
      .rst         (rst),
      .tft_rst     (tft_rst),
      .tft_cs      (tft_cs),
      .tft_clk     (tft_clk),
      .tft_din     (tft_din),
      .tft_dc      (tft_dc),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_is_cmd (byte_is_cmd),
      .pix_valid   (pix_valid),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_data    (pix_data),
      .cmd_err     (cmd_err)
`ifdef ILI_MON_STATS_EN
      ,
      .cmd_count   (cmd_count),
      .pix_count   (pix_count)
`endif
   );

   always #5 sysclk = ~sysclk;

   // Log output pulses on the falling edge, away from the active edge
   always @(negedge sysclk) begin
      if (byte_valid) begin
         byte_q.push_back({byte_is_cmd, byte_data});
         bv_t_q.push_back($time);
      end
      if (pix_valid) pix_q.push_back({pix_x, pix_y, pix_data});
      if (byte_valid && pix_valid) overlap++;
   end

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] byte_at(input int i);
      if (i < byte_q.size()) return {27'd0, byte_q[i]};
      return '1;
   endfunction

   function automatic logic [35:0] pix_at(input int i);
      if (i < pix_q.size()) return {2'd0, pix_q[i]};
      return '1;
   endfunction

   function automatic logic [35:0] lat_at(input int i);
      if (i < bv_t_q.size() && i < rise_q.size()) return 36'(bv_t_q[i] - rise_q[i]);
      return '1;
   endfunction

   function automatic logic [35:0] px(input int x, input int y, input logic [15:0] d);
      return {2'd0, 9'(x), 9'(y), d};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   task automatic clear_logs();
      byte_q.delete();
      pix_q.delete();
      bv_t_q.delete();
      rise_q.delete();
   endtask

   // Send the top n bits of v, MSB first; all edges land on sysclk negedges
   task automatic spi_bits(input logic [7:0] v, input int n, input logic dc);
      tft_dc = dc;
      for (int i = 0; i < n; i++) begin
         tft_din = v[7-i];
         #40 tft_clk = 1'b1;
         if (i == 7) rise_q.push_back($time);
         #40 tft_clk = 1'b0;
      end
   endtask

   task automatic cmd(input logic [7:0] v);
      spi_bits(v, 8, 1'b0);
   endtask

   task automatic dat(input logic [7:0] v);
      spi_bits(v, 8, 1'b1);
   endtask

   task automatic cs_low();
      tft_cs = 1'b0;
      #40;
   endtask

   task automatic cs_high();
      #40 tft_cs = 1'b1;
      idle(12);
   endtask

   initial begin
      rst = 1'b1; tft_rst = 1'b1; tft_cs = 1'b1;
      tft_clk = 1'b0; tft_din = 1'b0; tft_dc = 1'b0;
      idle(4);
      check("rst_byte_valid", {35'd0, byte_valid}, 36'd0);
      check("rst_pix_valid",  {35'd0, pix_valid},  36'd0);
      check("rst_pix",        {2'd0, pix_x, pix_y, pix_data}, 36'd0);
      check("rst_cmd_err",    {35'd0, cmd_err},    36'd0);
      check("rst_byte_data",  {27'd0, byte_is_cmd, byte_data}, 36'd0);
      rst = 1'b0;
      idle(4);

      // CASET 10..19, then fill a 10x2 window to see the x wrap
      clear_logs();
      cs_low();
      cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h13);
      cs_high();
      check("caset_nbytes", 36'(byte_q.size()), 36'd5);
      check("caset_b0", byte_at(0), {27'd0, 1'b1, 8'h2A});
      check("caset_b2", byte_at(2), {27'd0, 1'b0, 8'h0A});
      check("caset_b4", byte_at(4), {27'd0, 1'b0, 8'h13});
      check("lat_b0", lat_at(0), 36'd40);
      check("lat_b4", lat_at(4), 36'd40);
      check("caset_err", {35'd0, cmd_err}, 36'd0);
      clear_logs();
      cs_low();
      cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
      cmd(8'h2C);
      for (int i = 0; i < 11; i++) begin
         dat(8'(i)); dat(8'(8'h50 + i));
      end
      cs_high();
      check("win_npix", 36'(pix_q.size()), 36'd11);
      check("win_p0",  pix_at(0),  px(10, 0, 16'h0050));
      check("win_p9",  pix_at(9),  px(19, 0, 16'h0959));
      check("win_p10", pix_at(10), px(10, 1, 16'h0A5A));

      // 2x2 window, four colours, then a fifth pixel wraps the frame
      clear_logs();
      cs_low();
      cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
      cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
      cmd(8'h2C);
      dat(8'hF8); dat(8'h00); dat(8'h07); dat(8'hE0);
      dat(8'h00); dat(8'h1F); dat(8'hFF); dat(8'hFF);
      dat(8'h12); dat(8'h34);
      cs_high();
      check("rgb_nbytes", 36'(byte_q.size()), 36'd21);
      check("rgb_npix", 36'(pix_q.size()), 36'd5);
      check("rgb_p0", pix_at(0), px(0, 0, 16'hF800));
      check("rgb_p1", pix_at(1), px(1, 0, 16'h07E0));
      check("rgb_p2", pix_at(2), px(0, 1, 16'h001F));
      check("rgb_p3", pix_at(3), px(1, 1, 16'hFFFF));
      check("rgb_wrap", pix_at(4), px(0, 0, 16'h1234));

      // Deselect after 5 bits, then a whole byte; it becomes a pending high byte
      clear_logs();
      cs_low();
      spi_bits(8'hFF, 5, 1'b1);
      cs_high();
      cs_low();
      dat(8'hA5);
      cs_high();
      check("abort_nbytes", 36'(byte_q.size()), 36'd1);
      check("abort_byte", byte_at(0), {27'd0, 1'b0, 8'hA5});
      check("abort_npix", 36'(pix_q.size()), 36'd0);
      cs_low();
      dat(8'h5A);
      cs_high();
      check("hi_survives_cs", pix_at(0), px(1, 0, 16'hA55A));

      // Inverted CASET is rejected and leaves the 2x2 window in place
      clear_logs();
      cs_low();
      cmd(8'h2A); dat(8'h00); dat(8'h20); dat(8'h00); dat(8'h10);
      cs_high();
      check("bad_caset_err", {35'd0, cmd_err}, 36'd1);
      cs_low();
      cmd(8'h2C);
      dat(8'h00); dat(8'h01); dat(8'h00); dat(8'h02); dat(8'h00); dat(8'h03);
      cs_high();
      check("keep_p0", pix_at(0), px(0, 0, 16'h0001));
      check("keep_p1", pix_at(1), px(1, 0, 16'h0002));
      check("keep_p2", pix_at(2), px(0, 1, 16'h0003));
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("rst_clears_err", {35'd0, cmd_err}, 36'd0);
      idle(4);

      // Boundary: CASET 0..239 is legal, PASET 0..320 is not
      clear_logs();
      cs_low();
      cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'hEF);
      cs_high();
      check("caset_239_ok", {35'd0, cmd_err}, 36'd0);
      cs_low();
      cmd(8'h2C);
      dat(8'h00); dat(8'h04); dat(8'h00); dat(8'h05);
      cs_high();
      check("dflt_p0", pix_at(0), px(0, 0, 16'h0004));
      check("dflt_p1", pix_at(1), px(1, 0, 16'h0005));
      cs_low();
      cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h01); dat(8'h40);
      cs_high();
      check("paset_320_err", {35'd0, cmd_err}, 36'd1);
      tft_rst = 1'b0;
      idle(6);
      tft_rst = 1'b1;
      idle(6);
      check("tft_rst_clears_err", {35'd0, cmd_err}, 36'd0);

      // Command mid-pixel drops the high byte; SKIP ignores data
      clear_logs();
      cs_low();
      cmd(8'h2C); dat(8'hAB); cmd(8'h00); dat(8'hCD); dat(8'hEF);
      cs_high();
      check("skip_npix", 36'(pix_q.size()), 36'd0);
      check("skip_nbytes", 36'(byte_q.size()), 36'd5);
      cs_low();
      cmd(8'h2C); dat(8'h12); dat(8'h34);
      cs_high();
      check("clean_npix", 36'(pix_q.size()), 36'd1);
      check("clean_p0", pix_at(0), px(0, 0, 16'h1234));

      check("no_overlap", 36'(overlap), 36'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ili9341_spi_monitor.md
Name: ili9341_spi_monitor

Overview:
- Receive-side model of the ILI9341 4-wire SPI link, i.e. the display end of the link that ili9341_driver_top drives.
- Oversamples tft_cs/tft_clk/tft_din/tft_dc on sysclk, deserialises bytes and tags each as command or data.
- Decodes CASET (0x2A), PASET (0x2B) and RAMWR (0x2C), and emits one addressed 16-bit pixel per completed RAMWR pixel.
- Used in simulation benches and as an on-chip loopback checker beside the driver.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per SPI input (minimum 2).
- WIDTH, 240, column count; default column window end is WIDTH-1.
- HEIGHT, 320, row count; default page window end is HEIGHT-1.

Ports:
- sysclk  in  1  system clock; must run at ≥4× the tft_clk rate.
- rst  in  1  synchronous reset, active-high.
- tft_rst  in  1  display reset, active-low (synchronised internally).
- tft_cs  in  1  chip select, active-low.
- tft_clk  in  1  SPI clock, mode 0 (idle low, sample on rising edge).
- tft_din  in  1  serial data, MSB first.
- tft_dc  in  1  0 = command byte, 1 = data byte; sampled with bit 0.
- byte_valid  out  1  one-cycle pulse, one per received byte.
- byte_data  out  8  received byte.
- byte_is_cmd  out  1  qualifies byte_data as a command byte.
- pix_valid  out  1  one-cycle pulse, one per completed pixel.
- pix_x  out  9  column of the pixel.
- pix_y  out  9  row of the pixel.
- pix_data  out  16  RGB565 pixel value, high byte first on the wire.
- cmd_err  out  1  sticky error flag; cleared by rst or tft_rst low.

Behaviour:
- Reset: on rst=1 at a sysclk edge, all outputs go to 0 and the FSM enters IDLE. Window resets to xs=0, xe=WIDTH-1, ys=0, ye=HEIGHT-1, with cursor at (0,0).
- tft_rst: a synchronised low level has the same effect as rst for the FSM, the window, the bit counter and cmd_err.
- Synchronisation: all SPI inputs pass through SYNC_STAGES flops.
- Edge detect: a rising edge of tft_clk is detected by comparing the synchronised value with its one-cycle-delayed copy.
- Bit capture: on each detected rising edge with synchronised cs=0, shift din into an 8-bit register and increment a 3-bit bit counter.
- Byte complete: on the 8th bit, the next cycle pulses byte_valid with byte_data and byte_is_cmd = ~dc.
- Latency: byte_valid occurs SYNC_STAGES+2 sysclk after the raw 8th rising edge.
- CS deassert mid-byte: synchronised cs=1 clears the bit counter and discards the partial byte. No byte_valid is issued and FSM state is kept.
- Decoder FSM states: IDLE, CASET(arg idx 0..3), PASET(arg idx 0..3), RAMWR_HI, RAMWR_LO, SKIP.
  - Command byte from any state: 0x2A → CASET idx 0; 0x2B → PASET idx 0; 0x2C → RAMWR_HI with cursor reset to (xs,ys); any other code → SKIP.
  - A command byte always discards a pending RAMWR high byte.
  - CASET/PASET: args arrive as start_hi, start_lo, end_hi, end_lo, forming 16-bit start/end values. The window is committed on the 4th arg, then the FSM goes to SKIP.
  - Window commit error: if start > end or end ≥ WIDTH (or HEIGHT for PASET), the window is not updated and cmd_err is set.
  - RAMWR data: RAMWR_HI latches the high byte and goes to RAMWR_LO. RAMWR_LO pulses pix_valid the cycle after the low byte, with the current cursor and {hi,lo}, then returns to RAMWR_HI.
  - Cursor advance: x++. When x == xe, x ← xs and y++. When y == ye as well, y ← ys (frame wrap).
  - IDLE/SKIP: data bytes are ignored, beyond their byte_valid pulse.
- The pending high byte survives a CS deassert; only a command byte or reset discards it.
- byte_valid and pix_valid may assert in consecutive cycles but never in the same cycle.

Optional Feature:
- ILI_MON_STATS_EN defined: adds outputs cmd_count[15:0] and pix_count[31:0].
  - Both are free-running and saturating.
  - Cleared by rst or tft_rst low.
  - pix_count counts pix_valid pulses; cmd_count counts command bytes.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ili9341_pkg holds:
  - command codes CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C;
  - the decoder state enum;
  - the default window constants.
- One natural sub-module, ili9341_spi_rx: synchronisers, edge detect and shift register, producing byte_valid/byte_data/byte_is_cmd. The parent holds the command decoder and address generator.

Test Plan:
- Send command 0x2A, then data 00 0A 00 13 → 5 byte_valid pulses, the first with byte_is_cmd=1; window xs=10, xe=19; cmd_err=0.
- Send CASET 0..1, PASET 0..1, RAMWR, then data F8 00 07 E0 00 1F FF FF → 4 pix_valid pulses at (0,0)=F800, (1,0)=07E0, (0,1)=001F, (1,1)=FFFF.
- Continue that stream with a 5th pixel 12 34 → pix_valid at (0,0)=1234 (frame wrap).
- Raise tft_cs after 5 bits, then send a full byte A5 → exactly one byte_valid, with 0xA5.
- Send CASET with 00 20 00 10 (start > end) → cmd_err=1 and window unchanged; then rst=1 for one cycle → cmd_err=0 and window 0..239 × 0..319.
- Send RAMWR, data AB, then command 0x00 → no pix_valid; the state is SKIP, and the next RAMWR starts cleanly with a high byte.
